// File: rtl/reram_func_core.sv
// Functional model of a 32x32 ReRAM array with a command sequencer and a sensed-result FIFO.
// Optional macro RERAM_TIMING_EN: when defined, PROGRAM/ERASE/SENSE use WR_CYCLES/RD_CYCLES busy lengths.
`timescale 1ns/1ps
module reram_func_core #(
  parameter int WR_CYCLES  = 8,
  parameter int RD_CYCLES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        EN,
  input  logic        R_WB,
  input  logic [31:0] DI,
  input  logic [3:0]  SEL,
  input  logic [31:0] AD,
  output logic [31:0] DO,
  output logic        func_ack
);

  localparam int MAXN = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);

`ifdef RERAM_TIMING_EN
  localparam logic [CW-1:0] N_WR = CW'(WR_CYCLES);
  localparam logic [CW-1:0] N_RD = CW'(RD_CYCLES);
`else
  localparam logic [CW-1:0] N_WR = CW'(1);
  localparam logic [CW-1:0] N_RD = CW'(1);
`endif
  localparam logic [CW-1:0] N_ONE = CW'(1);

  localparam logic [1:0] OP_SENSE = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   n_load;
  logic            rd_q;
  logic [1:0]      op_q;
  logic [4:0]      row_q, col_q;
  logic            done;

  logic [31:0]     array_q [32] = '{default: '0};
  logic [10:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     occ_q;
  logic            ovf_q;
  logic            fifo_full, fifo_empty, push, sense_bit;
  logic [10:0]     head;
  logic            unused_ok;

  assign unused_ok  = ^{SEL, AD, DI[19:0]};
  assign done       = (state_q == S_BUSY) && (cnt_q == N_ONE);
  assign fifo_full  = (occ_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign sense_bit  = array_q[row_q][col_q];
  assign head       = fifo_q[rd_ptr_q];
  assign push       = done && !rd_q && (op_q == OP_SENSE) && !fifo_full && !RSTin;

  // Reads and NOPs complete after a single busy cycle.
  always_comb begin
    n_load = N_ONE;
    if (!R_WB) begin
      if (DI[31:30] == OP_SENSE) n_load = N_RD;
      else if (DI[31])           n_load = N_WR;
    end
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (EN) begin
        state_d = S_BUSY;
        cnt_d   = n_load;
      end
      S_BUSY: if (cnt_q == N_ONE) state_d = S_ACK;
              else                cnt_d   = cnt_q - N_ONE;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    func_ack = (state_q == S_ACK);
  end

  // Array and FIFO storage are not reset; the array is non-volatile.
  always_ff @(posedge CLKin) begin
    if (!RSTin && done && !rd_q && op_q[1]) array_q[row_q][col_q] <= op_q[0];
    if (push) fifo_q[wr_ptr_q] <= {row_q, col_q, sense_bit};
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      rd_q     <= 1'b0;
      op_q     <= 2'b00;
      row_q    <= '0;
      col_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      DO       <= '0;
    end else begin
      if (state_q == S_IDLE && EN) begin
        rd_q  <= R_WB;
        op_q  <= DI[31:30];
        row_q <= DI[29:25];
        col_q <= DI[24:20];
      end
      if (done) begin
        if (rd_q) begin
          ovf_q <= 1'b0;
          if (!fifo_empty) begin
            DO       <= {1'b1, ovf_q, 15'b0, head[10:6], head[5:1], 4'b0, head[0]};
            rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q    <= occ_q - 1'b1;
          end else begin
            DO <= {1'b0, ovf_q, 30'b0};
          end
        end else if (op_q == OP_SENSE) begin
          if (fifo_full) begin
            ovf_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            occ_q    <= occ_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reram_func_core.sv
// Directed bench for reram_func_core: command latency, sensed data, FIFO overflow and mid-operation reset.
`timescale 1ns/1ps
module tb_reram_func_core;

`ifdef RERAM_TIMING_EN
  localparam int WR_N   = 8;
  localparam int RD_N   = 4;
  localparam int RST_AT = 3;
`else
  localparam int WR_N   = 1;
  localparam int RD_N   = 1;
  localparam int RST_AT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        r_wb;
  logic [31:0] di;
  logic [3:0]  sel;
  logic [31:0] ad;
  logic [31:0] do_w;
  logic        ack;

  int checks   = 0;
  int failures = 0;

  reram_func_core dut (
    .CLKin    (clk),
    .RSTin    (rst),
    .EN       (en),
    .R_WB     (r_wb),
    .DI       (di),
    .SEL      (sel),
    .AD       (ad),
    .DO       (do_w),
    .func_ack (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; EN is held until the ack is seen, then dropped.
  task automatic txn(input string tag, input logic rw, input logic [31:0] cmd, input int exp_lat,
                     input logic chk_do, input logic [31:0] exp_do, input logic noisy);
    int lat;
    lat  = 0;
    r_wb = rw;
    di   = cmd;
    en   = 1'b1;
    @(negedge clk);
    while (ack !== 1'b1 && lat < 40) begin
      if (noisy) begin
        en = ~en;
        di = 32'hC020_0000;
      end
      @(negedge clk);
      lat++;
    end
    en = 1'b0;
    check_int({tag, " latency"}, lat, exp_lat);
    if (chk_do) check_vec({tag, " DO"}, do_w, exp_do);
    @(negedge clk);
    check_vec({tag, " ack width"}, {31'b0, ack}, 32'h0);
  endtask

  initial begin
    int acks;
    rst  = 1'b1;
    en   = 1'b0;
    r_wb = 1'b0;
    di   = '0;
    sel  = 4'hF;
    ad   = '0;
    repeat (3) @(negedge clk);
    check_vec("reset DO", do_w, 32'h0);
    check_vec("reset ack", {31'b0, ack}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    txn("program r3c5", 1'b0, 32'hC650_0000, WR_N, 1'b0, 32'h0, 1'b0);
    txn("sense r3c5",   1'b0, 32'h4650_0000, RD_N, 1'b0, 32'h0, 1'b0);
    txn("read one",     1'b1, 32'h0,         1,    1'b1, 32'h8000_0CA1, 1'b0);
    txn("erase r3c5",   1'b0, 32'h8650_0000, WR_N, 1'b0, 32'h0, 1'b0);
    txn("sense erased", 1'b0, 32'h4650_0000, RD_N, 1'b0, 32'h0, 1'b0);
    txn("read zero",    1'b1, 32'h0,         1,    1'b1, 32'h8000_0CA0, 1'b0);
    txn("read empty",   1'b1, 32'h0,         1,    1'b1, 32'h0000_0000, 1'b0);
    txn("nop",          1'b0, 32'h0000_0000, 1,    1'b0, 32'h0, 1'b0);

    for (int r = 0; r < 5; r++)
      txn("sense burst", 1'b0, 32'h4000_0000 | (32'(r) << 25), RD_N, 1'b0, 32'h0, 1'b0);
    txn("burst read1", 1'b1, 32'h0, 1, 1'b1, 32'hC000_0000, 1'b0);
    txn("burst read2", 1'b1, 32'h0, 1, 1'b1, 32'h8000_0400, 1'b0);
    txn("burst read3", 1'b1, 32'h0, 1, 1'b1, 32'h8000_0800, 1'b0);
    txn("burst read4", 1'b1, 32'h0, 1, 1'b1, 32'h8000_0C00, 1'b0);
    txn("burst read5", 1'b1, 32'h0, 1, 1'b1, 32'h0000_0000, 1'b0);

    // PROGRAM r7 c9 aborted by a one-cycle reset.
    acks = 0;
    r_wb = 1'b0;
    di   = 32'hCE90_0000;
    en   = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (k == RST_AT) begin
        rst = 1'b1;
        en  = 1'b0;
      end
      if (k == RST_AT + 1) rst = 1'b0;
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    check_int("aborted program acks", acks, 0);
    check_vec("aborted program DO", do_w, 32'h0);

    txn("sense r7c9 noisy", 1'b0, 32'h4E90_0000, RD_N, 1'b0, 32'h0, 1'b1);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    check_int("no second ack", acks, 0);
    txn("read r7c9", 1'b1, 32'h0, 1, 1'b1, 32'h8000_1D20, 1'b0);

    txn("sense r0c2", 1'b0, 32'h4020_0000, RD_N, 1'b0, 32'h0, 1'b0);
    txn("read r0c2",  1'b1, 32'h0,         1,    1'b1, 32'h8000_0040, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
